hex_display_scanner: RTL and testbench

Parametrised multi-digit hexadecimal display driver for the board's seven-segment displays. It latches an N-digit hex value and produces registered segment patterns in two forms: one static bus per digit, and a time-multiplexed single-digit bus with a one-hot digit enable. It adds leading-zero blanking, whole-display blinking and selectable output polarity. It sits between a datapath result register and the display pins, replacing per-digit combinational decoders.

---
 rtl/hex_display_scanner.sv | 127 ++++++++++++
 tb/tb_hex_display_scanner.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/hex_display_scanner.sv
// Multi-digit hex seven-segment driver: static per-digit bus plus time-multiplexed
// single-digit bus, with leading-zero blanking, whole-display blink and selectable polarity.
module hex_display_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 12500000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic [7*NUM_DIGITS-1:0] seg_all,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic POL_LOW = (ACTIVE_LOW != 0);

  localparam logic [SCAN_W-1:0]  SCAN_RELOAD  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_RELOAD = BLINK_W'(BLINK_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST     = IDX_W'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] disp_q;
  logic                    blank_lz_q, blink_en_q;
  logic [SCAN_W-1:0]       scan_cnt_q, scan_cnt_d;
  logic [BLINK_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                    blink_phase_q, blink_phase_d;
  logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
  logic [7*NUM_DIGITS-1:0] seg_all_q, seg_all_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    scan_tc, blink_tc, blink_off, all_zero;

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: glyph = 7'b0111111;
      4'h1: glyph = 7'b0000110;
      4'h2: glyph = 7'b1011011;
      4'h3: glyph = 7'b1001111;
      4'h4: glyph = 7'b1100110;
      4'h5: glyph = 7'b1101101;
      4'h6: glyph = 7'b1111101;
      4'h7: glyph = 7'b0000111;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1100111;
      4'hA: glyph = 7'b1110111;
      4'hB: glyph = 7'b1111100;
      4'hC: glyph = 7'b0111001;
      4'hD: glyph = 7'b1011110;
      4'hE: glyph = 7'b1111001;
      default: glyph = 7'b1110001;
    endcase
  endfunction

  // Timers are down-counters; a wrap is the terminal count at zero.
  always_comb begin
    scan_tc       = (scan_cnt_q == '0);
    scan_cnt_d    = scan_tc ? SCAN_RELOAD : scan_cnt_q - SCAN_W'(1);
    blink_tc      = (blink_cnt_q == '0);
    blink_cnt_d   = blink_tc ? BLINK_RELOAD : blink_cnt_q - BLINK_W'(1);
    blink_phase_d = blink_phase_q ^ blink_tc;
    digit_idx_d   = digit_idx_q;
    if (scan_tc)
      digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + IDX_W'(1);
    blink_off = blink_en_q & blink_phase_d;
  end

  // Patterns below are active-high; polarity is applied at the output registers.
  always_comb begin
    all_zero  = 1'b1;
    seg_all_d = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero & (disp_q[4*i +: 4] == 4'd0);
      if (!(blink_off || (i != 0 && blank_lz_q && all_zero)))
        seg_all_d[7*i +: 7] = glyph(disp_q[4*i +: 4]);
    end
  end

  always_comb begin
    seg_d = '0;
    an_d  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx_d == IDX_W'(i)) begin
        seg_d   = seg_all_d[7*i +: 7];
        an_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_q        <= '0;
      blank_lz_q    <= 1'b0;
      blink_en_q    <= 1'b0;
      scan_cnt_q    <= SCAN_RELOAD;
      blink_cnt_q   <= BLINK_RELOAD;
      blink_phase_q <= 1'b0;
      digit_idx_q   <= '0;
      seg_all_q     <= {(7*NUM_DIGITS){POL_LOW}};
      seg_q         <= {7{POL_LOW}};
      an_q          <= {NUM_DIGITS{POL_LOW}};
    end else begin
      if (load)
        disp_q <= value;
      blank_lz_q    <= blank_lz;
      blink_en_q    <= blink_en;
      scan_cnt_q    <= scan_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      digit_idx_q   <= digit_idx_d;
      seg_all_q     <= POL_LOW ? ~seg_all_d : seg_all_d;
      seg_q         <= POL_LOW ? ~seg_d : seg_d;
      an_q          <= POL_LOW ? ~an_d : an_d;
    end
  end

  assign seg_all = seg_all_q;
  assign seg     = seg_q;
  assign an      = an_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner: one active-low and one active-high instance
// driven by the same stimulus, NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=16.
module tb_hex_display_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        blink_en = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [27:0] seg_all_l, seg_all_h;
  logic [6:0]  seg_l, seg_h;
  logic [3:0]  an_l, an_h;

  int n_checks = 0;
  int n_errors = 0;
  int edge_n = 0;

  logic [6:0] glyph_tab [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1100111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  always #5 clk = ~clk;

  hex_display_scanner #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(16), .ACTIVE_LOW(1)) dut_lo (
    .clk(clk), .reset(reset), .value(value), .load(load), .blank_lz(blank_lz),
    .blink_en(blink_en), .seg_all(seg_all_l), .seg(seg_l), .an(an_l)
  );

  hex_display_scanner #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(16), .ACTIVE_LOW(0)) dut_hi (
    .clk(clk), .reset(reset), .value(value), .load(load), .blank_lz(blank_lz),
    .blink_en(blink_en), .seg_all(seg_all_h), .seg(seg_h), .an(an_h)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // edge_n counts edges since reset was last released (0 while in reset).
  task automatic tick();
    @(posedge clk);
    if (reset) edge_n = 0;
    else       edge_n++;
    #1;
  endtask

  function automatic int idx_of(input int e);
    return (e / 4) % 4;
  endfunction

  function automatic logic blink_off_at(input int e);
    return ((e / 16) % 2) == 1;
  endfunction

  function automatic logic [27:0] model(input logic [15:0] v, input logic blz, input logic off);
    logic [27:0] r;
    logic        upper;
    r = '0;
    upper = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      upper = upper && (v[4*i +: 4] == 4'h0);
      if (!off && !(i != 0 && blz && upper))
        r[7*i +: 7] = glyph_tab[v[4*i +: 4]];
    end
    return r;
  endfunction

  logic [27:0] exp_l;
  logic [15:0] prev_v;
  logic [6:0]  g;

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_seg_all_l", {4'h0, seg_all_l}, 32'h0FFFFFFF);
    check("rst_seg_l", {25'h0, seg_l}, 32'h7F);
    check("rst_an_l", {28'h0, an_l}, 32'hF);
    check("rst_seg_all_h", {4'h0, seg_all_h}, 32'h0);
    check("rst_an_h", {28'h0, an_h}, 32'h0);

    // First edge after release
    reset = 1'b0;
    tick();
    check("rel_seg_all", {4'h0, seg_all_l}, {4'h0, {4{7'b1000000}}});
    check("rel_an", {28'h0, an_l}, 32'hE);

    // Load 1A2F, walk the scan
    value = 16'h1A2F; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    exp_l = {7'b1111001, 7'b0001000, 7'b0100100, 7'b0001110};
    check("ld1A2F_seg_all", {4'h0, seg_all_l}, {4'h0, exp_l});
    for (int k = 0; k < 16; k++) begin
      check("scan_an", {28'h0, an_l}, {28'h0, ~(4'b0001 << idx_of(edge_n))});
      check("scan_seg", {25'h0, seg_l}, {25'h0, exp_l[7*idx_of(edge_n) +: 7]});
      tick();
    end

    // Leading-zero blanking
    blank_lz = 1'b1; value = 16'h0030; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    check("lz0030", {4'h0, seg_all_l}, {4'h0, 7'h7F, 7'h7F, 7'b0110000, 7'b1000000});
    value = 16'h0000; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    check("lz0000", {4'h0, seg_all_l}, {4'h0, 7'h7F, 7'h7F, 7'h7F, 7'b1000000});
    check("lz0000_hi", {4'h0, seg_all_h}, {4'h0, 21'h0, 7'b0111111});

    // Blink with 8888
    blank_lz = 1'b0; blink_en = 1'b1; value = 16'h8888; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    for (int k = 0; k < 40; k++) begin
      check("blink_seg_all", {4'h0, seg_all_l}, blink_off_at(edge_n) ? 32'h0FFFFFFF : 32'h0);
      check("blink_seg", {25'h0, seg_l}, blink_off_at(edge_n) ? 32'h7F : 32'h0);
      check("blink_an", {28'h0, an_l}, {28'h0, ~(4'b0001 << idx_of(edge_n))});
      tick();
    end

    // Load every cycle
    blink_en = 1'b0;
    tick();
    tick();
    prev_v = 16'h8888;
    for (int j = 0; j < 20; j++) begin
      value = 16'h1000 + 16'(j) * 16'h0111;
      load = 1'b1;
      tick();
      check("stream_seg_all", {4'h0, seg_all_l}, {4'h0, ~model(prev_v, 1'b0, 1'b0)});
      check("stream_an", {28'h0, an_l}, {28'h0, ~(4'b0001 << idx_of(edge_n))});
      prev_v = value;
    end
    load = 1'b0;

    // Reset during digit 2 with load asserted
    for (int k = 0; k < 16 && idx_of(edge_n) != 2; k++) tick();
    check("reach_digit2", {28'h0, an_l}, 32'hB);
    reset = 1'b1; load = 1'b1; value = 16'hFFFF;
    tick();
    check("midrst_seg_all", {4'h0, seg_all_l}, 32'h0FFFFFFF);
    check("midrst_an", {28'h0, an_l}, 32'hF);
    reset = 1'b0; load = 1'b0;
    tick();
    check("postrst_seg_all", {4'h0, seg_all_l}, {4'h0, {4{7'b1000000}}});
    check("postrst_seg", {25'h0, seg_l}, 32'h40);
    check("postrst_an", {28'h0, an_l}, 32'hE);

    // Glyph sweep on the active-high instance
    for (int h = 0; h < 16; h++) begin
      value = {4{4'(h)}}; load = 1'b1;
      tick();
      load = 1'b0;
      tick();
      g = glyph_tab[h];
      check("sweep_seg_all_h", {4'h0, seg_all_h}, {4'h0, g, g, g, g});
      check("sweep_seg_h", {25'h0, seg_h}, {25'h0, g});
      check("sweep_an_h", {28'h0, an_h}, {28'h0, 4'b0001 << idx_of(edge_n)});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
